hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central hazard and stall controller for the 5-stage pipeline (D/E/M/W pipeline registers, multiply/divide unit).
- Drives the PC enable, D-register enable, E-register flush and the four forwarding-mux selects.
- Keeps its own shadow pipeline of destination, write-enable and Tnew per stage, so only D-stage decode information is needed as input.
- Tracks the multi-cycle MD unit, interlocks HI/LO-using instructions, and counts stall cycles.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult leaves E
- DIV_CYCLES, 10, busy cycles after a div leaves E
- CNT_W, 32, stall counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- rsD  in  5  rs field of instruction in D
- rtD  in  5  rt field of instruction in D
- TuseRsD  in  2  rs use time: 0=D stage, 1=E stage, 3=unused
- TuseRtD  in  2  rt use time, same encoding
- DstD  in  5  destination register of D instruction
- RFWrD  in  1  D instruction writes RF
- TnewD  in  2  cycles after entering E until result exists: 0=PC8, 1=ALU, 2=load
- mdStartD  in  1  D instruction is mult/div
- mdDivD  in  1  1=div, 0=mult (valid with mdStartD)
- mdUseD  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- enPC  out  1  PC enable
- enD  out  1  D-register enable
- FlushE  out  1  bubble into E register
- FwdRsD  out  2  rs forward in D: 0=RF, 1=M, 2=W
- FwdRtD  out  2  rt forward in D, same encoding
- FwdRsE  out  2  rs forward in E, same encoding
- FwdRtE  out  2  rt forward in E, same encoding
- md_busy  out  1  MD unit busy
- stall_cnt  out  CNT_W  total stall cycles since reset

Behaviour:
- stall (internal, combinational) = stall_rs | stall_rt | stall_md. Outputs: enPC = enD = ~stall; FlushE = stall.
- stall_rs = (rsD != 0) & TuseRsD != 3 & one of:
  - RFWrE & DstE == rsD & TnewE > TuseRsD;
  - RFWrM & DstM == rsD & TnewM > TuseRsD.
- stall_rt: same as stall_rs with rt.
- stall_md = mdUseD & md_busy.
- md_busy = startE | (md_cnt != 0).
- Shadow stage E holds {rs, rt, Dst, RFWr, Tnew, start, div}. Update on each clk:
  - stall=1: E loads all-zero bubble.
  - else: E loads the D inputs.
- Shadow stage M holds {Dst, RFWr, Tnew}, loaded from E. TnewM = (TnewE == 0) ? 0 : TnewE − 1 (saturating).
- Shadow stage W holds {Dst, RFWr}, loaded from M.
- M and W shadows never stall or flush.
- Forwarding, rs (rt identical), using the D-stage register for D and the E shadow rs/rt for E:
  - 1 if RFWrM & DstM == reg & reg != 0 & TnewM == 0;
  - else 2 if RFWrW & DstW == reg & reg != 0;
  - else 0.
  - M has priority over W.
- A stalled D-stage operand's forward select is don't-care.
- MD counter md_cnt, with priority:
  - if startE, load md_cnt = divE ? DIV_CYCLES : MULT_CYCLES at the next clk;
  - else if md_cnt != 0, decrement.
- A new mult/div in D while busy stalls through stall_md, so the counter never reloads while nonzero.
- stall_cnt increments by 1 on each clk with stall=1 and wraps at 2^CNT_W.
- Reset (rst_n=0 at clk): all shadow registers, md_cnt and stall_cnt go to 0.
  - Result: md_busy=0 and stall_cnt=0.
  - With idle D inputs (TuseRsD = TuseRtD = 3, mdUseD = 0): enPC=1, enD=1, FlushE=0, all Fwd=0.
  - Reset in the middle of a div aborts tracking immediately.
- Latency: stall and forward outputs are combinational from the current D inputs and registered shadow state. Shadow state updates once per clk.

Test Plan:
1. lw $1 (TnewD=2), then addu $2,$1,$3 (TuseRs=1) -> exactly 1 stall cycle (enPC=0, FlushE=1); next cycle no stall; with addu in E, FwdRsE=2.
2. addu $1 (TnewD=1), then beq $1,$0 (TuseRs=0) -> 1 stall cycle; next cycle FwdRsD=1; stall_cnt=1.
3. addu $0 as producer, consumer reads $0 -> no stall, all Fwd=0.
4. mult, then mflo immediately -> stall for 6 consecutive cycles (startE + counter 5..1); md_busy drops as mflo proceeds; stall_cnt +6. For div: 11 cycles.
5. div issued; rst_n=0 for one clk 3 cycles later -> md_cnt=0, md_busy=0, stall_cnt=0 after that clk; a following mflo is not stalled.
6. $5 written by an instruction in M (TnewM=0) and in W simultaneously, consumer in E reads $5 -> FwdRsE=1 (M priority).

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central hazard / stall / forwarding controller for the
// 5-stage pipeline with a multi-cycle multiply/divide unit.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   rsD, rtD             source registers of the instruction in D
//   TuseRsD, TuseRtD     operand use time (0=D, 1=E, 3=unused)
//   DstD, RFWrD, TnewD   destination, RF write enable, result latency
//   mdStartD, mdDivD     D instruction starts a mult (0) / div (1)
//   mdUseD               D instruction touches the MD unit or HI/LO
//   enPC, enD, FlushE    stall controls (stall freezes PC/D, bubbles E)
//   FwdRsD/RtD/RsE/RtE   forward selects: 0=RF, 1=M, 2=W
//   md_busy              MD unit busy
//   stall_cnt            stall cycles since reset (wraps)
//
// Only D-stage decode data enters; E/M/W producer information is kept in a
// private shadow pipeline that moves in step with the real one.

// Per-operand RAW stall check against producers in E and M.
module hazard_chk (
    input  logic [4:0] src,
    input  logic [1:0] tuse,
    input  logic [4:0] dst_e,
    input  logic       wr_e,
    input  logic [1:0] tnew_e,
    input  logic [4:0] dst_m,
    input  logic       wr_m,
    input  logic [1:0] tnew_m,
    output logic       stall
);
    logic hit_e, hit_m;
    assign hit_e = wr_e && (dst_e == src) && (tnew_e > tuse);
    assign hit_m = wr_m && (dst_m == src) && (tnew_m > tuse);
    // $0 never carries a dependency; Tuse=3 marks an unused operand.
    assign stall = (src != 5'd0) && (tuse != 2'd3) && (hit_e || hit_m);
endmodule

// Per-operand forward select; M wins over W since it is the younger result.
module hazard_fwd (
    input  logic [4:0] src,
    input  logic [4:0] dst_m,
    input  logic       wr_m,
    input  logic [1:0] tnew_m,
    input  logic [4:0] dst_w,
    input  logic       wr_w,
    output logic [1:0] fwd
);
    always_comb begin
        fwd = 2'd0;
        if (src != 5'd0) begin
            if (wr_m && dst_m == src && tnew_m == 2'd0)
                fwd = 2'd1;
            else if (wr_w && dst_w == src)
                fwd = 2'd2;
        end
    end
endmodule

module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [1:0]       TuseRsD,
    input  logic [1:0]       TuseRtD,
    input  logic [4:0]       DstD,
    input  logic             RFWrD,
    input  logic [1:0]       TnewD,
    input  logic             mdStartD,
    input  logic             mdDivD,
    input  logic             mdUseD,
    output logic             enPC,
    output logic             enD,
    output logic             FlushE,
    output logic [1:0]       FwdRsD,
    output logic [1:0]       FwdRtD,
    output logic [1:0]       FwdRsE,
    output logic [1:0]       FwdRtE,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int MD_MAX  = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int MD_W    = $clog2(MD_MAX + 1);
    localparam int NUM_OPS = 4;  // rsD, rtD, rsE, rtE

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic       wr;
        logic [1:0] tnew;
        logic       start;
        logic       div;
    } e_stage_t;

    typedef struct packed {
        logic [4:0] dst;
        logic       wr;
        logic [1:0] tnew;
    } m_stage_t;

    typedef struct packed {
        logic [4:0] dst;
        logic       wr;
    } w_stage_t;

    e_stage_t         sh_e;
    m_stage_t         sh_m;
    w_stage_t         sh_w;
    logic [MD_W-1:0]  md_cnt;
    logic             stall;
    logic             stall_md;
    logic [1:0]       stall_op;

    // ---------------- stall detection ----------------
    logic [1:0][4:0] chk_src;
    logic [1:0][1:0] chk_tuse;
    assign chk_src  = {rtD, rsD};
    assign chk_tuse = {TuseRtD, TuseRsD};

    for (genvar g = 0; g < 2; g++) begin : g_chk
        hazard_chk u_chk (
            .src    (chk_src[g]),
            .tuse   (chk_tuse[g]),
            .dst_e  (sh_e.dst),
            .wr_e   (sh_e.wr),
            .tnew_e (sh_e.tnew),
            .dst_m  (sh_m.dst),
            .wr_m   (sh_m.wr),
            .tnew_m (sh_m.tnew),
            .stall  (stall_op[g])
        );
    end

    // A mult/div sitting in E has not loaded the counter yet, so it counts
    // as busy on its own.
    assign md_busy  = sh_e.start || (md_cnt != '0);
    assign stall_md = mdUseD && md_busy;
    assign stall    = |stall_op || stall_md;

    assign enPC   = ~stall;
    assign enD    = ~stall;
    assign FlushE = stall;

    // ---------------- forwarding ----------------
    logic [NUM_OPS-1:0][4:0] fwd_src;
    logic [NUM_OPS-1:0][1:0] fwd_sel;
    assign fwd_src = {sh_e.rt, sh_e.rs, rtD, rsD};

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
        hazard_fwd u_fwd (
            .src    (fwd_src[g]),
            .dst_m  (sh_m.dst),
            .wr_m   (sh_m.wr),
            .tnew_m (sh_m.tnew),
            .dst_w  (sh_w.dst),
            .wr_w   (sh_w.wr),
            .fwd    (fwd_sel[g])
        );
    end

    assign FwdRsD = fwd_sel[0];
    assign FwdRtD = fwd_sel[1];
    assign FwdRsE = fwd_sel[2];
    assign FwdRtE = fwd_sel[3];

    // ---------------- shadow pipeline, MD counter, stall counter ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_e      <= '0;
            sh_m      <= '0;
            sh_w      <= '0;
            md_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            if (stall)
                sh_e <= '0;
            else
                sh_e <= '{rs: rsD, rt: rtD, dst: DstD, wr: RFWrD, tnew: TnewD,
                          start: mdStartD, div: mdDivD};

            sh_m.dst  <= sh_e.dst;
            sh_m.wr   <= sh_e.wr;
            sh_m.tnew <= (sh_e.tnew == 2'd0) ? 2'd0 : sh_e.tnew - 2'd1;

            sh_w.dst  <= sh_m.dst;
            sh_w.wr   <= sh_m.wr;

            if (sh_e.start)
                md_cnt <= sh_e.div ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
            else if (md_cnt != '0)
                md_cnt <= md_cnt - MD_W'(1);

            stall_cnt <= stall_cnt + CNT_W'(stall);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rsD, rtD, DstD;
    logic [1:0]  TuseRsD, TuseRtD, TnewD;
    logic        RFWrD, mdStartD, mdDivD, mdUseD;
    logic        enPC, enD, FlushE, md_busy;
    logic [1:0]  FwdRsD, FwdRtD, FwdRsE, FwdRtE;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .rsD(rsD), .rtD(rtD), .TuseRsD(TuseRsD),
        .TuseRtD(TuseRtD), .DstD(DstD), .RFWrD(RFWrD), .TnewD(TnewD),
        .mdStartD(mdStartD), .mdDivD(mdDivD), .mdUseD(mdUseD), .enPC(enPC),
        .enD(enD), .FlushE(FlushE), .FwdRsD(FwdRsD), .FwdRtD(FwdRtD),
        .FwdRsE(FwdRsE), .FwdRtE(FwdRtE), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    // Reference model: each in-flight instruction remembers the absolute
    // cycle its result becomes available; MD busy is an absolute end cycle.
    typedef struct {
        int rs;
        int rt;
        int dst;
        bit wr;
        int ready;
    } ins_t;

    ins_t        mE, mM, mW;
    int          cyc = 0;
    int          md_end = -1;
    logic [31:0] cnt_exp = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int rem(ins_t p);
        return (p.ready > cyc) ? p.ready - cyc : 0;
    endfunction

    function automatic bit hz(int r, int tu);
        if (r == 0 || tu == 3) return 1'b0;
        return (mE.wr && mE.dst == r && rem(mE) > tu) ||
               (mM.wr && mM.dst == r && rem(mM) > tu);
    endfunction

    function automatic int fw(int r);
        if (r == 0) return 0;
        if (mM.wr && mM.dst == r && rem(mM) == 0) return 1;
        if (mW.wr && mW.dst == r) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        mE = '{default: 0};
        mM = '{default: 0};
        mW = '{default: 0};
        md_end = -1;
        cnt_exp = 0;
    endtask

    // One clock: check all outputs at the falling edge, advance the model at
    // the rising edge. dut_st reports what the DUT did.
    task automatic cycle(output bit st, output bit dut_st);
        bit srs, srt, smd;
        @(negedge clk);
        srs = hz(int'(rsD), int'(TuseRsD));
        srt = hz(int'(rtD), int'(TuseRtD));
        smd = mdUseD && (cyc <= md_end);
        st  = srs | srt | smd;
        dut_st = ~enPC;
        chk("enPC", 32'(enPC), 32'(!st));
        chk("enD", 32'(enD), 32'(!st));
        chk("FlushE", 32'(FlushE), 32'(st));
        chk("md_busy", 32'(md_busy), 32'(cyc <= md_end));
        chk("stall_cnt", stall_cnt, cnt_exp);
        chk("FwdRsE", 32'(FwdRsE), 32'(fw(mE.rs)));
        chk("FwdRtE", 32'(FwdRtE), 32'(fw(mE.rt)));
        if (!srs) chk("FwdRsD", 32'(FwdRsD), 32'(fw(int'(rsD))));
        if (!srt) chk("FwdRtD", 32'(FwdRtD), 32'(fw(int'(rtD))));
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            mW = mM;
            mM = mE;
            if (st) begin
                mE = '{default: 0};
            end else begin
                mE = '{rs: int'(rsD), rt: int'(rtD), dst: int'(DstD), wr: RFWrD,
                       ready: cyc + 1 + int'(TnewD)};
                if (mdStartD) md_end = cyc + 1 + (mdDivD ? 10 : 5);
            end
            cnt_exp += 32'(st);
        end
        cyc++;
        #1;
    endtask

    // Present one instruction in D and hold it until the model accepts it.
    // nst counts cycles in which the DUT stalled it.
    task automatic issue(input int rs, input int rt, input int tur, input int tut,
                         input int dst, input int wr, input int tnew,
                         input int mds, input int mdd, input int mdu, output int nst);
        bit st, dst_st, done;
        rsD = 5'(rs); rtD = 5'(rt); TuseRsD = 2'(tur); TuseRtD = 2'(tut);
        DstD = 5'(dst); RFWrD = 1'(wr); TnewD = 2'(tnew);
        mdStartD = 1'(mds); mdDivD = 1'(mdd); mdUseD = 1'(mdu);
        nst = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            cycle(st, dst_st);
            nst += int'(dst_st);
            done = !st;
        end
        if (!done) chk("issue_timeout", 32'd1, 32'd0);
    endtask

    task automatic idle(output int nst);
        issue(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, nst);
    endtask

    task automatic do_reset();
        bit st, dst_st;
        rst_n = 1'b0;
        rsD = '0; rtD = '0; TuseRsD = 2'd3; TuseRtD = 2'd3; DstD = '0;
        RFWrD = 0; TnewD = '0; mdStartD = 0; mdDivD = 0; mdUseD = 0;
        cycle(st, dst_st);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int tsel[3] = '{0, 1, 3};

        // Power-up reset: DUT state unknown before the first edge.
        rsD = '0; rtD = '0; TuseRsD = 2'd3; TuseRtD = 2'd3; DstD = '0;
        RFWrD = 0; TnewD = '0; mdStartD = 0; mdDivD = 0; mdUseD = 0;
        @(posedge clk); #1;
        model_reset();
        rst_n = 1'b1;

        // Reset state with idle inputs
        chk("rst_enPC", 32'(enPC), 32'd1);
        chk("rst_FlushE", 32'(FlushE), 32'd0);
        chk("rst_md_busy", 32'(md_busy), 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_fwd", 32'({FwdRsD, FwdRtD, FwdRsE, FwdRtE}), 32'd0);

        // 1: lw $1 ; addu $2,$1,$3
        issue(0, 0, 3, 3, 1, 1, 2, 0, 0, 0, n);
        issue(1, 3, 1, 1, 2, 1, 1, 0, 0, 0, n);
        chk("t1_stalls", 32'(n), 32'd1);
        rsD = '0; rtD = '0; TuseRsD = 2'd3; TuseRtD = 2'd3; RFWrD = 0; DstD = '0;
        #1 chk("t1_FwdRsE", 32'(FwdRsE), 32'd2);
        idle(n);

        // 2: addu $1 ; beq $1,$0
        do_reset();
        issue(0, 0, 1, 1, 1, 1, 1, 0, 0, 0, n);
        issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, n);
        chk("t2_stalls", 32'(n), 32'd1);
        chk("t2_stall_cnt", stall_cnt, 32'd1);

        // 3: producer writes $0, consumer reads $0
        do_reset();
        issue(0, 0, 1, 1, 0, 1, 1, 0, 0, 0, n);
        issue(0, 0, 0, 0, 4, 1, 1, 0, 0, 0, n);
        chk("t3_stalls", 32'(n), 32'd0);

        // 4: mult then mflo; div then mflo
        do_reset();
        issue(2, 3, 1, 1, 0, 0, 0, 1, 0, 1, n);
        issue(0, 0, 3, 3, 4, 1, 1, 0, 0, 1, n);
        chk("t4_mult_stalls", 32'(n), 32'd6);
        chk("t4_mult_cnt", stall_cnt, 32'd6);
        do_reset();
        issue(2, 3, 1, 1, 0, 0, 0, 1, 1, 1, n);
        issue(0, 0, 3, 3, 4, 1, 1, 0, 0, 1, n);
        chk("t4_div_stalls", 32'(n), 32'd11);
        chk("t4_div_cnt", stall_cnt, 32'd11);

        // 5: reset in the middle of a div
        do_reset();
        issue(2, 3, 1, 1, 0, 0, 0, 1, 1, 1, n);
        idle(n); idle(n); idle(n);
        do_reset();
        chk("t5_md_busy", 32'(md_busy), 32'd0);
        chk("t5_stall_cnt", stall_cnt, 32'd0);
        issue(0, 0, 3, 3, 4, 1, 1, 0, 0, 1, n);
        chk("t5_mflo_stalls", 32'(n), 32'd0);

        // 6: $5 in both M and W, consumer in E -> M wins
        do_reset();
        issue(0, 0, 3, 3, 5, 1, 1, 0, 0, 0, n);
        issue(0, 0, 3, 3, 5, 1, 1, 0, 0, 0, n);
        issue(5, 0, 1, 3, 6, 1, 1, 0, 0, 0, n);
        rsD = '0; TuseRsD = 2'd3; TuseRtD = 2'd3; RFWrD = 0; DstD = '0;
        #1 chk("t6_FwdRsE", 32'(FwdRsE), 32'd1);
        idle(n);

        // Randomized traffic on a small register set, with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end else begin
                int kind = int'($urandom_range(9));
                int rs   = int'($urandom_range(3));
                int rt   = int'($urandom_range(3));
                int tur  = tsel[$urandom_range(2)];
                int tut  = tsel[$urandom_range(2)];
                if (kind == 0)
                    issue(rs, rt, tur, tut, 0, 0, 0, 1, int'($urandom_range(1)), 1, n);
                else if (kind == 1)
                    issue(0, 0, 3, 3, int'($urandom_range(3)), 1, 1, 0, 0, 1, n);
                else
                    issue(rs, rt, tur, tut, int'($urandom_range(3)), int'($urandom_range(1)),
                          int'($urandom_range(2)), 0, 0, 0, n);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
